result_collector: RTL and testbench
===================================

RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of FIFO entries (power of two, 2..16).
REQ-003 Parameter CNT_W, default 8, SHALL set the width of the operation cycle counter.
REQ-004 clk  in  1  rising-edge clock, shared with the upstream data/control pair.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 y  in  8  upstream result data.
REQ-007 s  in  3  upstream step/state value.
REQ-008 b  in  1  upstream flag.
REQ-009 active  in  1  upstream busy indicator.
REQ-010 regime  in  2  upstream operating mode.
REQ-011 r_valid  out  1  FIFO head holds a record.
REQ-012 r_ready  in  1  consumer accepts the head record.
REQ-013 r_y, r_s, r_b, r_regime  out  8/3/1/2  head record fields.
REQ-014 r_cycles  out  CNT_W  active-cycle count of the head record.
REQ-015 level  out  clog2(DEPTH)+1  number of stored records.
REQ-016 overflow  out  1  sticky flag: at least one record dropped.
REQ-017 ovf_clr  in  1  clears overflow.

Function
REQ-018 active_q SHALL register active each cycle; rise = active & ~active_q; fall = ~active & active_q.
REQ-019 On a rise cycle, regime SHALL be latched into regime_q and cnt SHALL load 1.
REQ-020 On a cycle with active & active_q, cnt SHALL increment, saturating at 2^CNT_W-1 (no wrap).
REQ-021 On a fall cycle, one record {regime_q, b, s, y, cnt} SHALL be pushed, with y/s/b sampled in that same cycle.
REQ-022 A pushed record SHALL appear at the FIFO head with r_valid=1 on the cycle after the fall cycle when the FIFO was empty (first-word fall-through, 1-cycle latency).
REQ-023 Pop SHALL occur on a cycle with r_valid & r_ready; head fields SHALL be stable while r_valid & ~r_ready.
REQ-024 Push when level=DEPTH without a simultaneous pop SHALL drop the record and set overflow; contents SHALL remain unchanged.
REQ-025 Push and pop in the same cycle SHALL both take effect at any level, including full; level SHALL be unchanged.
REQ-026 Pop when empty SHALL be ignored; r_ready SHALL have no effect while r_valid=0.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH.
REQ-028 ovf_clr SHALL clear overflow; a drop in the same cycle SHALL take priority and leave overflow=1.
REQ-029 Head fields SHALL be don't-care while r_valid=0.

Reset
REQ-030 On rst: r_valid=0, level=0, overflow=0, pointers=0, cnt=0, regime_q=0, active_q=0.
REQ-031 Reset mid-operation SHALL abandon the partial record; if active is still 1 after reset, the next cycle SHALL be treated as a rise.

Structure
REQ-032 A shared package main_pkg SHALL hold DEPTH and CNT_W defaults and the record field widths (Y_W=8, S_W=3, REG_W=2).
REQ-033 Storage and pointers SHALL be a sub-module result_fifo; edge detection, counting and record assembly SHALL stay in the top module.

Verification
REQ-034 active high 5 cycles, regime=2 at rise, y=0xA5, s=3, b=1 at fall -> next cycle r_valid=1, r_y=0xA5, r_s=3, r_b=1, r_regime=2, r_cycles=5.
REQ-035 r_ready=0, 5 operations of 2 cycles each -> level=4, overflow=1, first 4 records retained in order; ovf_clr -> overflow=0.
REQ-036 FIFO full, fall coincides with r_valid & r_ready -> level stays 4, overflow stays 0, new record is last out.
REQ-037 active high 300 cycles, CNT_W=8 -> r_cycles=255.
REQ-038 rst asserted on the 3rd active cycle, active held high 4 more cycles -> single record with r_cycles=4.
REQ-039 Random r_ready back-pressure over 200 operations -> scoreboard order and field match, no loss while level<DEPTH.

Source files
------------

// File: rtl/main_pkg.sv
// Shared widths and defaults for the result collector.
// Record layout, MSB first: {regime, b, s, y, cycles}.
package main_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int Y_W       = 8;
  localparam int S_W       = 3;
  localparam int REG_W     = 2;

  function automatic int rec_width(input int cnt_w);
    return REG_W + 1 + S_W + Y_W + cnt_w;
  endfunction
endpackage

// File: rtl/result_fifo.sv
// First-word fall-through record FIFO with a sticky drop flag.
// A push is accepted when full only if a pop happens in the same cycle.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop_req,
  input  logic [W-1:0]  wdata,
  input  logic          ovf_clr,
  output logic [W-1:0]  rdata,
  output logic          valid,
  output logic [LW-1:0] level,
  output logic          overflow
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          drop;

  assign valid   = (level != '0);
  assign full    = (level == LW'(DEPTH));
  assign pop     = pop_req & valid;
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is plain binary rollover.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop)      level <= level + LW'(1);
      else if (pop && !do_push) level <= level - LW'(1);
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/result_collector.sv
// Watches the upstream busy indicator, counts active cycles and pushes one
// result record per operation into a small FIFO for a downstream consumer.
module result_collector
  import main_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Y_W-1:0]   y,
  input  logic [S_W-1:0]   s,
  input  logic             b,
  input  logic             active,
  input  logic [REG_W-1:0] regime,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [Y_W-1:0]   r_y,
  output logic [S_W-1:0]   r_s,
  output logic             r_b,
  output logic [REG_W-1:0] r_regime,
  output logic [CNT_W-1:0] r_cycles,
  output logic [LW-1:0]    level,
  output logic             overflow,
  input  logic             ovf_clr
);
  localparam int REC_W = rec_width(CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             active_q;
  logic             rise;
  logic             fall;
  logic             run;
  logic [REG_W-1:0] regime_q;
  logic [CNT_W-1:0] cnt;
  logic [REC_W-1:0] rec;
  logic [REC_W-1:0] head;

  assign rise = active & ~active_q;
  assign fall = ~active & active_q;
  assign run  = active & active_q;

  // Reset clears active_q, so an operation still running afterwards restarts as a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      regime_q <= '0;
      cnt      <= '0;
    end else begin
      active_q <= active;
      if (rise) begin
        regime_q <= regime;
        cnt      <= CNT_W'(1);
      end else if (run && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rec = {regime_q, b, s, y, cnt};

  result_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fall),
    .pop_req  (r_ready),
    .wdata    (rec),
    .ovf_clr  (ovf_clr),
    .rdata    (head),
    .valid    (r_valid),
    .level    (level),
    .overflow (overflow)
  );

  assign {r_regime, r_b, r_s, r_y, r_cycles} = head;
endmodule

// File: tb/tb_result_collector.sv
// Directed and randomized checks of result_collector at DEPTH=4, CNT_W=8.
module tb_result_collector;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] y = '0;
  logic [2:0] s = '0;
  logic       b = 1'b0;
  logic       active = 1'b0;
  logic [1:0] regime = '0;
  logic       r_valid;
  logic       r_ready = 1'b0;
  logic [7:0] r_y;
  logic [2:0] r_s;
  logic       r_b;
  logic [1:0] r_regime;
  logic [7:0] r_cycles;
  logic [2:0] level;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] y;
    logic [2:0] s;
    logic       b;
    logic [1:0] rg;
    logic [7:0] cyc;
  } rec_t;

  typedef struct {
    int   len;
    rec_t exp;
  } vec_t;

  result_collector #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .y(y), .s(s), .b(b), .active(active), .regime(regime),
    .r_valid(r_valid), .r_ready(r_ready), .r_y(r_y), .r_s(r_s), .r_b(r_b),
    .r_regime(r_regime), .r_cycles(r_cycles), .level(level),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_head(input string nm, input rec_t e);
    chk({nm, ".valid"}, 32'(r_valid), 32'd1);
    chk({nm, ".y"}, 32'(r_y), 32'(e.y));
    chk({nm, ".s"}, 32'(r_s), 32'(e.s));
    chk({nm, ".b"}, 32'(r_b), 32'(e.b));
    chk({nm, ".regime"}, 32'(r_regime), 32'(e.rg));
    chk({nm, ".cycles"}, 32'(r_cycles), 32'(e.cyc));
  endtask

  // One operation: len active cycles, then the fall cycle carrying y/s/b.
  // Returns at the negedge after the fall edge. regime is only honoured at rise.
  task automatic run_op(input int len, input rec_t r, input logic clr, input logic pop);
    for (int i = 0; i < len; i++) begin
      active = 1'b1;
      regime = (i == 0) ? r.rg : ~r.rg;
      step();
    end
    active = 1'b0;
    y = r.y; s = r.s; b = r.b;
    ovf_clr = clr; r_ready = pop;
    step();
    ovf_clr = 1'b0; r_ready = 1'b0;
  endtask

  task automatic pop_one();
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
  endtask

  function automatic rec_t mk(input logic [7:0] yv, input logic [2:0] sv, input logic bv,
                              input logic [1:0] rg, input logic [7:0] cyc);
    rec_t r;
    r.y = yv; r.s = sv; r.b = bv; r.rg = rg; r.cyc = cyc;
    return r;
  endfunction

  vec_t vecs[5];
  rec_t fill[6];
  rec_t q[$];
  rec_t rr;

  initial begin
    vecs[0] = '{len: 5, exp: mk(8'hA5, 3'd3, 1'b1, 2'd2, 8'd5)};
    vecs[1] = '{len: 1, exp: mk(8'h3C, 3'd7, 1'b0, 2'd1, 8'd1)};
    vecs[2] = '{len: 2, exp: mk(8'hFF, 3'd0, 1'b1, 2'd3, 8'd2)};
    vecs[3] = '{len: 7, exp: mk(8'h00, 3'd5, 1'b0, 2'd0, 8'd7)};
    vecs[4] = '{len: 3, exp: mk(8'h5A, 3'd2, 1'b1, 2'd1, 8'd3)};

    step(); step();
    rst = 1'b0;
    chk("reset.valid", 32'(r_valid), 32'd0);
    chk("reset.level", 32'(level), 32'd0);
    chk("reset.overflow", 32'(overflow), 32'd0);

    // r_ready while empty must not disturb anything
    pop_one();
    chk("empty_pop.level", 32'(level), 32'd0);
    chk("empty_pop.valid", 32'(r_valid), 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].len, vecs[i].exp, 1'b0, 1'b0);
      chk_head($sformatf("vec%0d", i), vecs[i].exp);
      chk($sformatf("vec%0d.level", i), 32'(level), 32'd1);
      step();
      chk($sformatf("vec%0d.hold_y", i), 32'(r_y), 32'(vecs[i].exp.y));
      pop_one();
      chk($sformatf("vec%0d.popped", i), 32'(r_valid), 32'd0);
    end

    // Overflow: five ops with no consumer, then a sixth drop with ovf_clr in the same cycle
    for (int i = 0; i < 6; i++) fill[i] = mk(8'h10 + 8'(i), 3'(i), 1'(i), 2'(i), 8'd2);
    for (int i = 0; i < 5; i++) run_op(2, fill[i], 1'b0, 1'b0);
    chk("ovf.level", 32'(level), 32'd4);
    chk("ovf.flag", 32'(overflow), 32'd1);
    run_op(2, fill[5], 1'b1, 1'b0);
    chk("ovf.drop_beats_clr", 32'(overflow), 32'd1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf.cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("ovf_order%0d", i), fill[i]);
      pop_one();
    end
    chk("ovf.drained", 32'(level), 32'd0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 4; i++) run_op(2, fill[i], 1'b0, 1'b0);
    run_op(3, mk(8'hC3, 3'd6, 1'b1, 2'd2, 8'd3), 1'b0, 1'b1);
    chk("full_pp.level", 32'(level), 32'd4);
    chk("full_pp.overflow", 32'(overflow), 32'd0);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("full_pp.order%0d", i), 32'(r_y), 32'(fill[i].y));
      pop_one();
    end
    chk_head("full_pp.last", mk(8'hC3, 3'd6, 1'b1, 2'd2, 8'd3));
    pop_one();
    chk("full_pp.empty", 32'(r_valid), 32'd0);

    // Counter saturation
    run_op(300, mk(8'h77, 3'd1, 1'b0, 2'd3, 8'd255), 1'b0, 1'b0);
    chk_head("sat", mk(8'h77, 3'd1, 1'b0, 2'd3, 8'd255));
    pop_one();

    // Reset on the 3rd active cycle, active held 4 more cycles
    active = 1'b1; regime = 2'd1; step();
    step();
    rst = 1'b1; step();
    rst = 1'b0;
    chk("midrst.level", 32'(level), 32'd0);
    regime = 2'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      regime = 2'd0;
    end
    active = 1'b0; y = 8'h42; s = 3'd4; b = 1'b1;
    step();
    chk_head("midrst", mk(8'h42, 3'd4, 1'b1, 2'd3, 8'd4));
    chk("midrst.level1", 32'(level), 32'd1);
    pop_one();

    // Random back-pressure against a reference queue
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    begin
      int drops = 0;
      for (int op = 0; op < 200; op++) begin
        int len = $urandom_range(1, 4);
        int idle = $urandom_range(0, 1);
        rr = mk(8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom), 8'(len));
        for (int c = 0; c < len + 1 + idle; c++) begin
          logic rdy;
          logic popped;
          rdy = 1'($urandom_range(0, 1));
          chk("rnd.valid", 32'(r_valid), 32'(q.size() != 0));
          if (rdy && q.size() != 0) chk_head("rnd", q[0]);
          popped = rdy && q.size() != 0;
          active = (c < len);
          regime = (c == 0) ? rr.rg : 2'($urandom);
          if (c == len) begin y = rr.y; s = rr.s; b = rr.b; end
          r_ready = rdy;
          step();
          if (popped) void'(q.pop_front());
          if (c == len) begin
            if (q.size() < 4) q.push_back(rr);
            else drops++;
          end
        end
      end
      r_ready = 1'b0;
      chk("rnd.level", 32'(level), 32'(q.size()));
      chk("rnd.overflow", 32'(overflow), 32'(drops != 0));
      while (q.size() != 0) begin
        chk_head("rnd.drain", q[0]);
        pop_one();
        void'(q.pop_front());
      end
      chk("rnd.empty", 32'(r_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
